// File: rtl/pe_frame_loader.sv
// Frame loader for one PE: collects stream words into a ping-pong buffer, bursts each full
// frame into the PE load port, then waits for the PE to return the frame's outputs.
module pe_frame_loader #(
  parameter int unsigned DW        = 32,
  parameter int unsigned LOAD_NUM  = 32,
  parameter int unsigned OUT_WORDS = 16,
  parameter int unsigned AW        = $clog2(LOAD_NUM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  output logic          s_ready,
  output logic          din_pe_v,
  output logic [DW-1:0] din_pe,
  input  logic          dout_pe_v,
  output logic          frame_done,
  output logic          busy,
  output logic [15:0]   frame_cnt,
  output logic          err_unexp
);

  localparam int unsigned   OCW       = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;
  localparam logic [AW-1:0]  LAST_ADDR = AW'(LOAD_NUM - 1);
  localparam logic [OCW-1:0] LAST_OUT  = OCW'(OUT_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_WAIT_DONE
  } state_t;

  state_t         state, state_n;
  logic [1:0]     full, full_n;
  logic           wb, rb;
  logic [AW-1:0]  waddr, raddr, raddr_n;
  logic [OCW-1:0] ocnt, ocnt_n;
  logic [DW-1:0]  mem [2][LOAD_NUM];

  logic wr_fire_c, wr_last_c;
  logic rd_en_c, rd_last_c, done_c, unexp_c;

  // Write side: a bank accepts words only while it is not full.
  assign s_ready   = ~full[wb];
  assign wr_fire_c = s_valid & s_ready;
  assign wr_last_c = wr_fire_c & (waddr == LAST_ADDR);

  // Bank storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (wr_fire_c) mem[wb][waddr] <= s_data;
  end

  // Read FSM next-state and control decode.
  always_comb begin
    state_n   = state;
    raddr_n   = raddr;
    ocnt_n    = ocnt;
    rd_en_c   = 1'b0;
    rd_last_c = 1'b0;
    done_c    = 1'b0;
    unexp_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        unexp_c = dout_pe_v;
        if (full[rb]) begin
          state_n = ST_BURST;
          raddr_n = '0;
        end
      end
      ST_BURST: begin
        unexp_c = dout_pe_v;
        rd_en_c = 1'b1;
        raddr_n = raddr + AW'(1);
        if (raddr == LAST_ADDR) begin
          rd_last_c = 1'b1;
          raddr_n   = '0;
          ocnt_n    = '0;
          state_n   = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (dout_pe_v) begin
          if (ocnt == LAST_OUT) begin
            done_c  = 1'b1;
            ocnt_n  = '0;
            state_n = ST_IDLE;
          end else begin
            ocnt_n = ocnt + OCW'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Fill and drain always touch different banks, so both updates can land together.
  always_comb begin
    full_n = full;
    if (rd_last_c) full_n[rb] = 1'b0;
    if (wr_last_c) full_n[wb] = 1'b1;
  end

  // State, pointers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      full       <= '0;
      wb         <= 1'b0;
      rb         <= 1'b0;
      waddr      <= '0;
      raddr      <= '0;
      ocnt       <= '0;
      din_pe_v   <= 1'b0;
      din_pe     <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
      err_unexp  <= 1'b0;
    end else begin
      state <= state_n;
      full  <= full_n;
      raddr <= raddr_n;
      ocnt  <= ocnt_n;
      if (wr_fire_c) waddr <= wr_last_c ? '0 : waddr + AW'(1);
      if (wr_last_c) wb <= ~wb;
      if (rd_last_c) rb <= ~rb;
      din_pe_v   <= rd_en_c;
      din_pe     <= rd_en_c ? mem[rb][raddr] : '0;
      frame_done <= done_c;
      busy       <= (state_n != ST_IDLE);
      if (done_c)  frame_cnt <= frame_cnt + 16'd1;
      if (unexp_c) err_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pe_frame_loader.sv
// Directed bench for pe_frame_loader: a scoreboard of stream words checked against din_pe,
// plus burst timing, frame completion, backpressure, spurious-output and reset checks.
module tb_pe_frame_loader;

  localparam int unsigned DW = 32;
  localparam int unsigned LN = 32;
  localparam int unsigned OW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic          din_pe_v;
  logic [DW-1:0] din_pe;
  logic          dout_pe_v = 1'b0;
  logic          frame_done;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic          err_unexp;

  pe_frame_loader #(.DW(DW), .LOAD_NUM(LN), .OUT_WORDS(OW)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .din_pe_v(din_pe_v), .din_pe(din_pe), .dout_pe_v(dout_pe_v),
    .frame_done(frame_done), .busy(busy), .frame_cnt(frame_cnt), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  logic [DW-1:0] sb[$];
  int n_sent = 0;
  int hs_cyc = 0;
  int last_pulse_cyc = 0;
  int exp_frames = 0;

  int bursts = 0;
  int run_len = 0;
  int last_run = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every din_pe beat and tracks burst runs.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v  = 1'b0;
      run_len = 0;
    end else begin
      if (din_pe_v) begin
        if (!prev_v) start_cyc = cyc;
        run_len++;
        n_cmp++;
        assert (sb.size() > 0) else begin
          n_err++;
          $error("FAIL din_extra: observed word %0h expected no word", din_pe);
        end
        if (sb.size() > 0) check("din_pe", din_pe, sb.pop_front());
      end else begin
        check("din_idle_zero", din_pe, 32'h0);
        if (prev_v) begin
          last_run = run_len;
          run_len  = 0;
          bursts++;
        end
      end
      if (frame_done) done_cnt++;
      prev_v = din_pe_v;
    end
  end

  // Called at a negedge; returns at the negedge right after the handshake edge.
  task automatic send_word(input logic [DW-1:0] w);
    int t = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (!s_ready && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      $display("FAIL send_timeout: observed s_ready stuck low expected a handshake");
      $fatal(1);
    end
    sb.push_back(w);
    @(negedge clk);
    hs_cyc = cyc;
    n_sent++;
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  task automatic pulse_dout(input int n);
    for (int i = 0; i < n; i++) begin
      dout_pe_v = 1'b1;
      @(negedge clk);
    end
    dout_pe_v = 1'b0;
    last_pulse_cyc = cyc;
  endtask

  task automatic wait_bursts(input int target, input string tag);
    int t = 0;
    while (bursts < target && t < 500) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    assert (bursts >= target) else begin
      n_err++;
      $error("FAIL %s: observed %0d bursts expected %0d", tag, bursts, target);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 32'h1);
    check({tag, "_din_v"}, 32'(din_pe_v), 32'h0);
    check({tag, "_din"}, din_pe, 32'h0);
    check({tag, "_done"}, 32'(frame_done), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_cnt"}, 32'(frame_cnt), 32'h0);
    check({tag, "_err"}, 32'(err_unexp), 32'h0);
  endtask

  initial begin
    int b0;
    int t;

    // Reset values
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Single frame, back-to-back input
    b0 = bursts;
    for (int i = 0; i < LN; i++) send_word(32'(i));
    @(negedge clk);
    check("sf_busy_early", 32'(busy), 32'h1);
    check("sf_no_din_yet", 32'(din_pe_v), 32'h0);
    wait_bursts(b0 + 1, "sf_burst");
    check("sf_latency", 32'(start_cyc), 32'(hs_cyc + 2));
    check("sf_run_len", 32'(last_run), 32'(LN));
    check("sf_sb_empty", 32'(sb.size()), 32'h0);
    check("sf_busy_wait", 32'(busy), 32'h1);
    pulse_dout(OW);
    exp_frames++;
    repeat (2) @(negedge clk);
    check("sf_done_pulses", 32'(done_cnt), 32'(exp_frames));
    check("sf_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("sf_busy_idle", 32'(busy), 32'h0);
    check("sf_err", 32'(err_unexp), 32'h0);

    // Backpressure: three frames streamed while the PE withholds outputs
    b0 = bursts;
    n_sent = 0;
    fork
      for (int i = 0; i < 3 * LN; i++) send_word(32'(100 + i));
    join_none
    wait_bursts(b0 + 1, "bp_burst1");
    check("bp_run1", 32'(last_run), 32'(LN));
    t = 0;
    while (n_sent < 3 * LN && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("bp_all_accepted", 32'(n_sent), 32'(3 * LN));
    repeat (5) @(negedge clk);
    check("bp_stall", 32'(s_ready), 32'h0);
    check("bp_busy", 32'(busy), 32'h1);
    pulse_dout(OW);
    exp_frames++;
    wait_bursts(b0 + 2, "bp_burst2");
    check("bp_gap2", 32'(start_cyc), 32'(last_pulse_cyc + 2));
    check("bp_run2", 32'(last_run), 32'(LN));
    check("bp_release", 32'(s_ready), 32'h1);
    pulse_dout(OW);
    exp_frames++;
    wait_bursts(b0 + 3, "bp_burst3");
    check("bp_gap3", 32'(start_cyc), 32'(last_pulse_cyc + 2));
    check("bp_run3", 32'(last_run), 32'(LN));
    pulse_dout(OW);
    exp_frames++;
    repeat (3) @(negedge clk);
    check("bp_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("bp_done_pulses", 32'(done_cnt), 32'(exp_frames));
    check("bp_sb_empty", 32'(sb.size()), 32'h0);
    check("bp_busy_idle", 32'(busy), 32'h0);

    // Gapped input still yields a gap-free burst
    b0 = bursts;
    for (int i = 0; i < LN; i++) begin
      send_word(32'(200 + i));
      @(negedge clk);
    end
    wait_bursts(b0 + 1, "gap_burst");
    check("gap_run_len", 32'(last_run), 32'(LN));
    pulse_dout(OW);
    exp_frames++;
    repeat (2) @(negedge clk);
    check("gap_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

    // Spurious PE output while idle
    pulse_dout(1);
    repeat (2) @(negedge clk);
    check("sp_err", 32'(err_unexp), 32'h1);
    check("sp_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("sp_done_pulses", 32'(done_cnt), 32'(exp_frames));
    b0 = bursts;
    for (int i = 0; i < LN; i++) send_word(32'hA000 + 32'(i));
    wait_bursts(b0 + 1, "sp_burst");
    check("sp_latency", 32'(start_cyc), 32'(hs_cyc + 2));
    pulse_dout(OW);
    exp_frames++;
    repeat (2) @(negedge clk);
    check("sp_frame_cnt2", 32'(frame_cnt), 32'(exp_frames));
    check("sp_err_sticky", 32'(err_unexp), 32'h1);

    // Reset in the middle of a burst
    for (int i = 0; i < LN; i++) send_word(32'hB000 + 32'(i));
    t = 0;
    while (run_len < 10 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("mr_reached_word10", 32'(run_len >= 10), 32'h1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mr");
    sb.delete();
    exp_frames = 0;
    done_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    b0 = bursts;
    for (int i = 0; i < LN; i++) send_word(32'hC000 + 32'(i));
    wait_bursts(b0 + 1, "mr_burst");
    check("mr_latency", 32'(start_cyc), 32'(hs_cyc + 2));
    check("mr_run_len", 32'(last_run), 32'(LN));
    pulse_dout(OW);
    exp_frames++;
    repeat (2) @(negedge clk);
    check("mr_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
    check("mr_err", 32'(err_unexp), 32'h0);
    check("mr_sb_empty", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
